// File: rtl/adc_sync_retry_ctrl.sv
// ADC SYNC / detect / evaluate sequencer with bounded retries, feeding the 4-channel sync checker.
// Optional periodic re-check while locked is enabled by defining SYNC_PERIODIC_RECHECK_EN.
//
// state       | meaning
// IDLE        | waiting for first start edge after reset
// SYNC_PULSE  | adc_sync_o asserted for SYNC_PULSE_CYCLES
// SETTLE      | lanes settling after SYNC
// DETECT      | detect_o asserted for DETECT_CYCLES (checker measurement window)
// WAIT_RESULT | waiting for checker's registered verdict
// EVAL        | one cycle; samples is_sync_i and decides lock / retry / fail
// LOCKED      | last evaluation passed (re-check timer runs when enabled)
// FAIL        | all attempts exhausted
module adc_sync_retry_ctrl #(
  parameter int SYNC_PULSE_CYCLES = 16,
  parameter int SETTLE_CYCLES     = 256,
  parameter int DETECT_CYCLES     = 1024,
  parameter int RESULT_WAIT       = 4,
  parameter int MAX_RETRY         = 7,
  parameter int RECHECK_PERIOD    = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       is_sync_i,
  output logic       adc_sync_o,
  output logic       detect_o,
  output logic       busy_o,
  output logic       locked_o,
  output logic       fail_o,
  output logic [7:0] retry_cnt_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DETECT = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_EVAL   = 3'd5;
  localparam logic [2:0] S_LOCKED = 3'd6;
  localparam logic [2:0] S_FAIL   = 3'd7;

`ifdef SYNC_PERIODIC_RECHECK_EN
  localparam int RECHECK_CYC = RECHECK_PERIOD;
`else
  // Period timer does not exist in this build, so it must not widen the counter.
  localparam int RECHECK_CYC = (RECHECK_PERIOD > 0) ? 1 : 1;
`endif

  localparam int MAX_A   = (SYNC_PULSE_CYCLES > SETTLE_CYCLES) ? SYNC_PULSE_CYCLES : SETTLE_CYCLES;
  localparam int MAX_B   = (DETECT_CYCLES > RESULT_WAIT) ? DETECT_CYCLES : RESULT_WAIT;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_AB > RECHECK_CYC) ? MAX_AB : RECHECK_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] LD_SYNC   = CNT_W'(SYNC_PULSE_CYCLES);
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] LD_DETECT = CNT_W'(DETECT_CYCLES);
  localparam logic [CNT_W-1:0] LD_WAIT   = CNT_W'(RESULT_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       MAX_RETRY_C = 8'(MAX_RETRY);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;
  logic             start_q;
  logic             adc_sync_q, detect_q, busy_q;
  logic             start_edge;
  logic             cnt_done;
  logic             reload;
  logic [7:0]       retry_inc;
`ifdef SYNC_PERIODIC_RECHECK_EN
  logic             recheck_q, recheck_d;
`endif

  assign start_edge = start_i & ~start_q;
  assign cnt_done   = (cnt_q == CNT_ONE);
  assign retry_inc  = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

  function automatic logic [CNT_W-1:0] load_for(input logic [2:0] s);
    logic [CNT_W-1:0] v;
    v = '0;
    case (s)
      S_SYNC:   v = LD_SYNC;
      S_SETTLE: v = LD_SETTLE;
      S_DETECT: v = LD_DETECT;
      S_WAIT:   v = LD_WAIT;
`ifdef SYNC_PERIODIC_RECHECK_EN
      S_LOCKED: v = CNT_W'(RECHECK_PERIOD);
`endif
      default:  v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    locked_d = locked_q;
    fail_d   = fail_q;
`ifdef SYNC_PERIODIC_RECHECK_EN
    recheck_d = recheck_q;
`endif
    if (start_edge) begin
      state_d  = S_SYNC;
      retry_d  = 8'd0;
      locked_d = 1'b0;
      fail_d   = 1'b0;
`ifdef SYNC_PERIODIC_RECHECK_EN
      recheck_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_SYNC:   if (cnt_done) state_d = S_SETTLE;
        S_SETTLE: if (cnt_done) state_d = S_DETECT;
        S_DETECT: if (cnt_done) state_d = S_WAIT;
        S_WAIT:   if (cnt_done) state_d = S_EVAL;
        S_EVAL: begin
          if (is_sync_i) begin
            state_d  = S_LOCKED;
            locked_d = 1'b1;
`ifdef SYNC_PERIODIC_RECHECK_EN
            recheck_d = 1'b0;
          end else if (recheck_q) begin
            // A failed re-check counts as the first failed attempt of a fresh sequence.
            state_d   = S_SYNC;
            locked_d  = 1'b0;
            retry_d   = 8'd1;
            recheck_d = 1'b0;
`endif
          end else if (retry_q < MAX_RETRY_C) begin
            state_d = S_SYNC;
            retry_d = retry_inc;
          end else begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
            retry_d = retry_inc;
          end
        end
`ifdef SYNC_PERIODIC_RECHECK_EN
        S_LOCKED: begin
          if (cnt_done) begin
            state_d   = S_DETECT;
            recheck_d = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // A restart from SYNC_PULSE keeps the same state, so the edge itself must force a reload.
  assign reload = start_edge | (state_d != state_q);

  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = load_for(state_d);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      retry_q    <= 8'd0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
      start_q    <= 1'b0;
      adc_sync_q <= 1'b0;
      detect_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SYNC_PERIODIC_RECHECK_EN
      recheck_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
      start_q    <= start_i;
      adc_sync_q <= (state_d == S_SYNC);
      detect_q   <= (state_d == S_DETECT);
      busy_q     <= (state_d == S_SYNC) || (state_d == S_SETTLE) || (state_d == S_DETECT) ||
                    (state_d == S_WAIT) || (state_d == S_EVAL);
`ifdef SYNC_PERIODIC_RECHECK_EN
      recheck_q  <= recheck_d;
`endif
    end
  end

  assign adc_sync_o  = adc_sync_q;
  assign detect_o    = detect_q;
  assign busy_o      = busy_q;
  assign locked_o    = locked_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_adc_sync_retry_ctrl.sv
// Scoreboard bench for adc_sync_retry_ctrl with a behavioural 4-lane sync checker model.
// Covers the SYNC_PERIODIC_RECHECK_EN build with RECHECK_PERIOD=32 when that macro is defined.
module tb_adc_sync_retry_ctrl;
  localparam int SYNC_N    = 4;
  localparam int SETTLE_N  = 8;
  localparam int DETECT_N  = 16;
  localparam int WAIT_N    = 4;
  localparam int MAXR      = 2;
  localparam int RECHECK_N = 32;
  localparam int BUDGET    = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       lanes_ok = 1'b1;
  logic       is_sync = 1'b0;
  logic       adc_sync_o, detect_o, busy_o, locked_o, fail_o;
  logic [7:0] retry_cnt_o;

  always #5 clk = ~clk;

  adc_sync_retry_ctrl #(
    .SYNC_PULSE_CYCLES(SYNC_N), .SETTLE_CYCLES(SETTLE_N), .DETECT_CYCLES(DETECT_N),
    .RESULT_WAIT(WAIT_N), .MAX_RETRY(MAXR), .RECHECK_PERIOD(RECHECK_N)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .is_sync_i(is_sync),
    .adc_sync_o(adc_sync_o), .detect_o(detect_o), .busy_o(busy_o),
    .locked_o(locked_o), .fail_o(fail_o), .retry_cnt_o(retry_cnt_o)
  );

  // Checker model: verdict = lanes aligned on every window cycle, visible 2 cycles after detect falls.
  logic det_d = 1'b0, ok_acc = 1'b0, stage1 = 1'b0;
  always @(posedge clk) begin
    det_d <= detect_o;
    if (detect_o) ok_acc <= det_d ? (ok_acc & lanes_ok) : lanes_ok;
    if (!detect_o && det_d) stage1 <= ok_acc;
    is_sync <= stage1;
  end

  typedef struct packed {
    logic       locked;
    logic       fail;
    logic [7:0] retry;
    logic [7:0] pulses;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   skip_req = 0;
  int   skip_done = 0;
  int   recheck_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles, expected level not reached", name, BUDGET);
  endtask

  task automatic push_exp(input logic l, input logic f, input int r, input int p);
    exp_t e;
    e.locked = l; e.fail = f; e.retry = 8'(r); e.pulses = 8'(p);
    exp_q.push_back(e);
  endtask

  // Monitor: measures pulse/window/gap widths and scores each completed sequence.
  int   sync_w = 0, det_w = 0, gap = 0, pulses = 0, idle = 0;
  logic gap_act = 1'b0, idle_act = 1'b0;
  logic p_sync = 1'b0, p_det = 1'b0, p_busy = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (busy_o && !p_busy) pulses = 0;
      if (adc_sync_o && !p_sync) begin pulses++; sync_w = 0; end
      if (adc_sync_o) sync_w++;
      if (!adc_sync_o && p_sync) begin
        chk("sync_width", sync_w, SYNC_N);
        gap_act = 1'b1;
        gap = 0;
      end
      if (gap_act && !adc_sync_o && !detect_o) gap++;
      if (detect_o && !p_det) begin
        if (gap_act) chk("settle_gap", gap, SETTLE_N);
        if (idle_act) chk("recheck_period", idle, RECHECK_N);
        gap_act = 1'b0;
        idle_act = 1'b0;
        det_w = 0;
      end
      if (busy_o && !p_busy) idle_act = 1'b0;
      if (detect_o) det_w++;
      if (!detect_o && p_det) begin
        if (skip_done < skip_req) skip_done++;
        else chk("detect_width", det_w, DETECT_N);
      end
      if (!busy_o) gap_act = 1'b0;
      if (!busy_o && p_busy) begin
`ifdef SYNC_PERIODIC_RECHECK_EN
        if (pulses == 0) begin
          recheck_seen++;
          chk("recheck_locked", int'(locked_o), 1);
          chk("recheck_retry", int'(retry_cnt_o), 0);
        end else
`endif
        if (exp_q.size() == 0) begin
          chk("unexpected_sequence_end", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("seq_locked", int'(locked_o), int'(e.locked));
          chk("seq_fail", int'(fail_o), int'(e.fail));
          chk("seq_retry", int'(retry_cnt_o), int'(e.retry));
          chk("seq_sync_pulses", pulses, int'(e.pulses));
        end
        idle_act = locked_o;
        idle = 0;
      end
      if (idle_act && !busy_o && !detect_o) idle++;
      p_sync = adc_sync_o;
      p_det  = detect_o;
      p_busy = busy_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_busy(input logic lvl);
    int n = 0;
    while (busy_o !== lvl && n < BUDGET) begin step(); n++; end
    if (busy_o !== lvl) timeout("wait_busy");
  endtask

  task automatic wait_det(input logic lvl);
    int n = 0;
    while (detect_o !== lvl && n < BUDGET) begin step(); n++; end
    if (detect_o !== lvl) timeout("wait_detect");
  endtask

  task automatic wait_sync(input logic lvl);
    int n = 0;
    while (adc_sync_o !== lvl && n < BUDGET) begin step(); n++; end
    if (adc_sync_o !== lvl) timeout("wait_adc_sync");
  endtask

  // Called right after wait_busy(0) so the edge lands before any re-check window can open.
  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_adc_sync", int'(adc_sync_o), 0);
    chk("rst_detect", int'(detect_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_fail", int'(fail_o), 0);
    chk("rst_retry", int'(retry_cnt_o), 0);
    rst = 1'b0;
    repeat (2) step();

    // Aligned lanes: single attempt locks.
    lanes_ok = 1'b1;
    push_exp(1'b1, 1'b0, 0, 1);
    pulse_start();
    chk("start_busy", int'(busy_o), 1);
    wait_busy(1'b0);

    // Misaligned on the first attempt only.
    wait_busy(1'b0);
    lanes_ok = 1'b0;
    push_exp(1'b1, 1'b0, 1, 2);
    pulse_start();
    wait_det(1'b1);
    wait_det(1'b0);
    lanes_ok = 1'b1;
    wait_busy(1'b0);

    // Never aligned: MAX_RETRY+1 attempts then FAIL.
    wait_busy(1'b0);
    lanes_ok = 1'b0;
    push_exp(1'b0, 1'b1, 3, 3);
    pulse_start();
    wait_busy(1'b0);
    lanes_ok = 1'b1;

    // One-cycle misalignment mid-window, started from FAIL.
    wait_busy(1'b0);
    push_exp(1'b1, 1'b0, 1, 2);
    pulse_start();
    chk("restart_from_fail_flag", int'(fail_o), 0);
    wait_det(1'b1);
    repeat (5) step();
    lanes_ok = 1'b0;
    step();
    lanes_ok = 1'b1;
    wait_busy(1'b0);

    // Restart edge inside the detect window.
    wait_busy(1'b0);
    push_exp(1'b1, 1'b0, 0, 2);
    pulse_start();
    wait_det(1'b1);
    repeat (3) step();
    skip_req++;
    start_i = 1'b1;
    step();
    chk("restart_detect_low", int'(detect_o), 0);
    chk("restart_adc_sync_high", int'(adc_sync_o), 1);
    chk("restart_retry", int'(retry_cnt_o), 0);
    chk("restart_busy", int'(busy_o), 1);
    start_i = 1'b0;
    wait_busy(1'b0);

    // Reset during SETTLE with start_i held high.
    wait_busy(1'b0);
    push_exp(1'b0, 1'b0, 0, 1);
    push_exp(1'b1, 1'b0, 0, 1);
    start_i = 1'b1;
    wait_sync(1'b1);
    wait_sync(1'b0);
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("midrst_adc_sync", int'(adc_sync_o), 0);
    chk("midrst_detect", int'(detect_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_locked", int'(locked_o), 0);
    chk("midrst_fail", int'(fail_o), 0);
    chk("midrst_retry", int'(retry_cnt_o), 0);
    rst = 1'b0;
    step();
    chk("postrst_busy", int'(busy_o), 1);
    chk("postrst_adc_sync", int'(adc_sync_o), 1);
    wait_busy(1'b0);

`ifdef SYNC_PERIODIC_RECHECK_EN
    begin
      int base = recheck_seen;
      int n = 0;
      while (recheck_seen < base + 2 && n < BUDGET) begin step(); n++; end
      chk("recheck_windows_seen", int'(recheck_seen >= base + 2), 1);
      chk("recheck_still_locked", int'(locked_o), 1);
    end
`else
    begin
      int det_hi = 0;
      repeat (100) begin
        step();
        if (detect_o) det_hi++;
      end
      chk("locked_terminal_no_detect", det_hi, 0);
      chk("locked_terminal_flag", int'(locked_o), 1);
    end
`endif
    start_i = 1'b0;

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < BUDGET) begin step(); n++; end
      chk("scoreboard_drained", exp_q.size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_sync_retry_ctrl.md
Name: adc_sync_retry_ctrl

Overview:
- Control stage directly upstream of the 4-channel ADC sync checker; drives the checker's detect input and consumes its sync result.
- Sequence: pulses ADC SYNC (core reset), waits for lanes to settle, opens a detect window, then samples the checker's registered verdict.
- Retries a bounded number of times; reports LOCKED or FAIL to the control/status register block.

Parameters:
- SYNC_PULSE_CYCLES, 16: width of adc_sync_o pulse in clk cycles (>=1)
- SETTLE_CYCLES, 256: wait after SYNC pulse before detection (>=1)
- DETECT_CYCLES, 1024: cycles detect_o held high (>=2)
- RESULT_WAIT, 4: cycles after detect_o falls before sampling is_sync_i (>=3; checker result is valid 2 cycles after detect falling edge)
- MAX_RETRY, 7: retries after first attempt before FAIL (0..255)
- RECHECK_PERIOD, 65536: idle cycles between re-checks while LOCKED (optional feature only)

Ports:
- clk  in  1  ADC-domain fabric clock, same clock as sync checker
- rst  in  1  synchronous active-high reset
- start_i  in  1  level/pulse; rising edge starts (or restarts) a sync sequence
- is_sync_i  in  1  sync checker ADC_Is_Sync output
- adc_sync_o  out  1  SYNC/reset request to ADC cores, active high
- detect_o  out  1  to checker detect_in; high = measurement window
- busy_o  out  1  sequence in progress (any state other than IDLE/LOCKED/FAIL)
- locked_o  out  1  last evaluation passed
- fail_o  out  1  retries exhausted without sync
- retry_cnt_o  out  8  attempts failed in current sequence (saturates at 255)

Behaviour:
- Every output is registered. Reset values: adc_sync_o=0, detect_o=0, busy_o=0, locked_o=0, fail_o=0, retry_cnt_o=0; state=IDLE; all counters=0.
- Synchronous reset mid-sequence: outputs return to reset values on the next edge; detect_o drops to 0 and the checker latches a meaningless verdict. This is harmless because no state samples it.
- start edge detection: start_q registered; edge = start_i & ~start_q. start_q resets to 0, so a start_i held high through reset triggers one sequence.
- States:
  - IDLE: wait for edge -> SYNC_PULSE; clears locked_o, fail_o, retry_cnt_o.
  - SYNC_PULSE: adc_sync_o=1 for exactly SYNC_PULSE_CYCLES cycles -> SETTLE.
  - SETTLE: wait SETTLE_CYCLES -> DETECT.
  - DETECT: detect_o=1 for exactly DETECT_CYCLES cycles -> WAIT_RESULT. detect_o is 0 in all other states, so each window produces exactly one rising and one falling edge.
  - WAIT_RESULT: wait RESULT_WAIT cycles -> EVAL.
  - EVAL (1 cycle): sample is_sync_i.
    - is_sync_i=1 -> LOCKED, locked_o=1.
    - is_sync_i=0 and retry_cnt_o<MAX_RETRY -> retry_cnt_o+1, go to SYNC_PULSE.
    - is_sync_i=0 and retry_cnt_o==MAX_RETRY -> FAIL, fail_o=1, retry_cnt_o+1.
  - LOCKED / FAIL: hold; an edge -> clear flags, retry_cnt_o=0, go to SYNC_PULSE.
- An edge in any busy state restarts at SYNC_PULSE with retry_cnt_o=0. Restart takes priority over all other transitions in the same cycle.
- busy_o=1 in SYNC_PULSE, SETTLE, DETECT, WAIT_RESULT, EVAL.
- Counter: one shared down-counter sized $clog2 of the largest of the cycle parameters, plus 1. It is loaded on state entry and the state exits when the count reaches 1, giving exact cycle counts.
- Total attempts = MAX_RETRY+1. MAX_RETRY=0 means a single attempt.

Optional Feature:
- Macro SYNC_PERIODIC_RECHECK_EN.
- Defined:
  - LOCKED counts RECHECK_PERIOD cycles, then enters DETECT with no SYNC pulse. locked_o stays 1 during the re-check.
  - On EVAL pass, return to LOCKED and restart the period.
  - On EVAL fail, locked_o=0, retry_cnt_o=1, enter SYNC_PULSE and follow the normal retry flow.
- Undefined: LOCKED is terminal until start_i edge; RECHECK_PERIOD is unused.

Test Plan:
Bench parameters: SYNC_PULSE_CYCLES=4, SETTLE_CYCLES=8, DETECT_CYCLES=16, RESULT_WAIT=4, MAX_RETRY=2, checker model instantiated.
- Start pulse, lanes aligned -> adc_sync_o high exactly 4 cycles; detect_o high exactly 16 cycles, starting 8 cycles after adc_sync_o falls; locked_o=1 at EVAL+1; retry_cnt_o=0; busy_o falls the same cycle.
- Lanes misaligned on attempt 1 only -> two adc_sync_o pulses; locked_o=1; retry_cnt_o=1.
- Lanes never aligned -> exactly 3 adc_sync_o pulses; fail_o=1; retry_cnt_o=3; locked_o=0.
- Misalign for 1 cycle mid-window -> checker drops, EVAL fails, retry issued; the next clean attempt locks.
- start_i edge during DETECT -> detect_o=0 next cycle; new 4-cycle adc_sync_o pulse; retry_cnt_o=0.
- rst asserted during SETTLE with start_i held high -> all outputs 0 the cycle after rst; after rst release a new sequence begins. With SYNC_PERIODIC_RECHECK_EN and RECHECK_PERIOD=32: a re-check window with no adc_sync_o occurs every 32 cycles after lock.
